// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a hold-time limit.
// A grant is held until done, withdrawal or TIMEOUT cycles elapse, then always idles for one cycle.
module rr_arb4 #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_ptr;
  logic [3:0] r_cnt;
  logic [1:0] r_gnt_idx;
  logic       r_timeout;

  logic [1:0] w_pick_idx;
  logic       w_rel_done;
  logic       w_rel_wdraw;
  logic       w_rel_cnt;
  logic       w_release;

  // Return the first set request, searching from ptr upward with wrap-around.
  function automatic logic [1:0] pick_first(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick_first = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick_first = idx;
    end
  endfunction

  assign w_pick_idx  = pick_first(req, r_ptr);
  assign w_rel_done  = done;
  assign w_rel_wdraw = !req[r_gnt_idx];
  assign w_rel_cnt   = (r_cnt == CNT_LAST);
  assign w_release   = w_rel_done || w_rel_wdraw || w_rel_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (|req)     w_next_state = S_GRANT;
      S_GRANT: if (w_release) w_next_state = S_IDLE;
      default:               w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr     <= 2'd0;
      r_cnt     <= 4'd0;
      r_gnt_idx <= 2'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt_idx <= w_pick_idx;
            r_cnt     <= 4'd0;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_ptr     <= r_gnt_idx + 2'd1;
            // Only a release caused purely by the counter is reported as a timeout.
            r_timeout <= w_rel_cnt && !w_rel_done && !w_rel_wdraw;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt_vld = (r_state == S_GRANT);
    gnt_idx = r_gnt_idx;
    timeout = r_timeout;
  end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum number of consecutive cycles one grant is held; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-004 Port: req  input  4  request vector; bit i = requester i wants the shared resource.
REQ-005 Port: done  input  1  current grantee finished; sampled only in GRANT.
REQ-006 Port: gnt_idx  output  2  registered binary index of granted requester; drives the downstream 2-to-4 one-hot decoder select.
REQ-007 Port: gnt_vld  output  1  registered; gnt_idx is valid and the grant is active.
REQ-008 Port: timeout  output  1  registered one-cycle pulse; grant was forcibly revoked.

Function
REQ-009 Block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-010 Block SHALL keep a 2-bit priority pointer ptr naming the highest-priority requester.
REQ-011 In IDLE with req != 0, block SHALL move to GRANT at the next edge, with gnt_idx = the first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), and gnt_vld = 1; latency is 1 cycle.
REQ-012 In IDLE with req == 0, block SHALL stay in IDLE with gnt_vld = 0 and gnt_idx unchanged.
REQ-013 In GRANT, gnt_idx SHALL stay stable until release.
REQ-014 Release conditions SHALL be evaluated each GRANT cycle on current inputs: done = 1, req[gnt_idx] = 0 (withdrawal), or hold counter = TIMEOUT-1.
REQ-015 On release, block SHALL return to IDLE at the next edge with gnt_vld = 0 for at least one cycle; back-to-back grants without an idle cycle SHALL NOT occur.
REQ-016 On release, ptr SHALL become gnt_idx+1 mod 4, wrapping 3 to 0.
REQ-017 Hold counter (4 bits) SHALL clear on entry to GRANT and increment each non-releasing GRANT cycle, so gnt_vld is high for at most TIMEOUT consecutive cycles.
REQ-018 timeout SHALL pulse high for exactly the first IDLE cycle after a release caused only by the counter; otherwise it is 0.
REQ-019 If done or withdrawal coincides with counter = TIMEOUT-1, release SHALL count as normal and timeout SHALL stay 0.
REQ-020 done asserted in IDLE SHALL be ignored.
REQ-021 done asserted in the first GRANT cycle SHALL produce a one-cycle grant.
REQ-022 Changes to req bits other than req[gnt_idx] during GRANT SHALL NOT affect the current grant.

Reset
REQ-023 When rst_n = 0 at a rising edge, block SHALL set state = IDLE, ptr = 0, counter = 0, gnt_idx = 2'b00, gnt_vld = 0, and timeout = 0, regardless of the other inputs.
REQ-024 Reset asserted mid-grant SHALL drop gnt_vld at that edge with no timeout pulse.
REQ-025 First arbitration after reset SHALL favour requester 0.

Verification
REQ-026 Reset: rst_n = 0 for 2 cycles, req = 1111, done = 1 -> gnt_vld = 0, gnt_idx = 00, timeout = 0 throughout.
REQ-027 Single request: req = 0100 from IDLE -> next cycle gnt_vld = 1, gnt_idx = 10; done pulse -> next cycle gnt_vld = 0, and the next grant search starts at 11.
REQ-028 Fairness: req = 1111 held, done pulsed in each grant's first cycle -> gnt_idx sequence 00, 01, 10, 11, 00, with gnt_vld = 0 for one cycle between grants.
REQ-029 Timeout: req = 0001, done = 0 -> gnt_vld high exactly 15 cycles, then timeout = 1 for one cycle with gnt_vld = 0, then gnt_idx = 00 regranted.
REQ-030 Withdrawal: grant on idx 01, req = 0010 drops to 0000 -> next cycle gnt_vld = 0, timeout = 0; ptr = 10.
REQ-031 Reset mid-grant: rst_n = 0 while gnt_vld = 1, gnt_idx = 11 -> next edge gnt_vld = 0, gnt_idx = 00; after release with req = 1001 -> grant to 00.
